// File: rtl/scramble_pipe.sv
// scramble_pipe -- multi-round pipelined scrambler with a per-round key file.
//
// Each round is one registered stage applying the reverse-rotate-and-select
// bit function R(d, k). Stages hand words forward with valid/ready flow
// control. A stage advances when it is empty or when the stage after it
// advances, so the pipe runs at one word per cycle and never drops or
// duplicates a word.
//
// Optional feature macro: SCRAMBLE_BYPASS_EN
//   When defined, the bypass port exists. A word accepted with bypass = 1
//   passes through every stage unmodified, with the same latency.
//
// Ports:
//   clk        clock, all state updates on rising edge
//   rst        synchronous active-high reset (clears stages and keys)
//   in_valid   input word valid
//   in_ready   block accepts the input word this cycle
//   in_data    plaintext word [WIDTH]
//   bypass     pass word through unscrambled (SCRAMBLE_BYPASS_EN only)
//   out_valid  scrambled word valid
//   out_ready  downstream accepts the output word
//   out_data   scrambled word [WIDTH]
//   key_we     key write strobe
//   key_idx    round key index to write (indices >= ROUNDS are ignored)
//   key_data   round key value [WIDTH]

module scramble_pipe #(
  parameter int WIDTH  = 5,
  parameter int ROUNDS = 2,
  parameter int OFFSET = 3,
  localparam int IDXW  = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
`ifdef SCRAMBLE_BYPASS_EN
  input  logic             bypass,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             key_we,
  input  logic [IDXW-1:0]  key_idx,
  input  logic [WIDTH-1:0] key_data
);

  // Round function. For output bit i the input is bit-reversed and then
  // rotated left by (i + OFFSET) mod WIDTH; taps g[0..4] of that copy plus
  // key bit k[i] select the output bit.
  function automatic logic [WIDTH-1:0] round_fn(input logic [WIDTH-1:0] d,
                                                input logic [WIDTH-1:0] k);
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] g;
    int s;
    res = '0;
    g   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s = (i + OFFSET) % WIDTH;
      // g[j] = r[(j - s) mod WIDTH] with r[x] = d[WIDTH-1-x]
      for (int j = 0; j < WIDTH; j++) begin
        g[j] = d[WIDTH - 1 - ((j - s + WIDTH) % WIDTH)];
      end
      res[i] = (~(g[3] | g[4] | g[0]) & g[1]) | (~g[2] & k[i]) | (g[2] & g[0]);
    end
    return res;
  endfunction

  logic [ROUNDS-1:0] v_all;          // stage valid bits
  logic [WIDTH-1:0]  d_all [ROUNDS]; // stage data words
  logic [ROUNDS-1:0] adv;            // stage loads on next edge
  logic [ROUNDS-1:0] byp_chain;      // bypass flag seen at each stage input
  logic              byp_in;

`ifdef SCRAMBLE_BYPASS_EN
  assign byp_in = bypass;
`else
  assign byp_in = 1'b0;
`endif

  assign byp_chain[0] = byp_in;

  genvar gi;
  generate
    for (gi = 0; gi < ROUNDS; gi++) begin : g_stage
      logic             v_reg;
      logic [WIDTH-1:0] d_reg;
      logic [WIDTH-1:0] key_reg;
      logic             up_valid;
      logic [WIDTH-1:0] up_data;

      // A stage can load if it, or any stage after it, is empty, or if the
      // consumer is taking the last word. Written as a flat AND so the
      // ready chain has no combinational self-reference.
      assign adv[gi] = out_ready | ~(&v_all[ROUNDS-1:gi]);

      assign v_all[gi] = v_reg;
      assign d_all[gi] = d_reg;

      if (gi == 0) begin : g_first
        assign up_valid = in_valid;
        assign up_data  = in_data;
      end else begin : g_next
        assign up_valid = v_all[gi-1];
        assign up_data  = d_all[gi-1];
      end

      // Key file entry. A write in the same cycle as a load is seen by the
      // stage only from the following edge, because the load reads key_reg.
      always_ff @(posedge clk) begin
        if (rst) begin
          key_reg <= '0;
        end else if (key_we && (key_idx == IDXW'(gi))) begin
          key_reg <= key_data;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          v_reg <= 1'b0;
          d_reg <= '0;
        end else if (adv[gi]) begin
          v_reg <= up_valid;
          d_reg <= byp_chain[gi] ? up_data : round_fn(up_data, key_reg);
        end
      end

      // The bypass flag travels with its word. The last stage never needs
      // it again, so only stages feeding another stage keep a flag bit.
      if (gi < ROUNDS - 1) begin : g_flag
        logic byp_reg;
        always_ff @(posedge clk) begin
          if (rst) begin
            byp_reg <= 1'b0;
          end else if (adv[gi]) begin
            byp_reg <= byp_chain[gi];
          end
        end
        assign byp_chain[gi+1] = byp_reg;
      end
    end
  endgenerate

  assign in_ready  = adv[0];
  assign out_valid = v_all[ROUNDS-1];
  assign out_data  = d_all[ROUNDS-1];

endmodule

// File: doc/scramble_pipe.md
Name: scramble_pipe

Overview:
Parametrised, multi-round pipelined scrambler with a programmable per-round key register file. Each round applies the team's reverse-rotate-and-select bit function: every output bit is derived from a rotated, bit-reversed copy of the round input plus one key bit. Rounds are registered stages with valid/ready flow control. The block sits between the data source and the downstream consumer on the scrambled-data path.

Parameters:
WIDTH, 5, data/key bit width; must be >= 5 (function taps g[0..4])
ROUNDS, 2, number of scramble rounds, one pipeline stage each; must be >= 1
OFFSET, 3, rotation base; output bit i uses rotation (i+OFFSET) mod WIDTH

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  input word valid
in_ready  output  1  block can accept the input word this cycle
in_data  input  WIDTH  plaintext word
out_valid  output  1  scrambled word valid
out_ready  input  1  downstream accepts the output word
out_data  output  WIDTH  scrambled word
key_we  input  1  key write strobe
key_idx  input  clog2(ROUNDS) (min 1)  round key index to write
key_data  input  WIDTH  round key value
bypass  input  1  present only with SCRAMBLE_BYPASS_EN

Behaviour:
- Round function R(d,k), for each i in 0..WIDTH-1:
  - r = bit-reverse of d, so r[j] = d[WIDTH-1-j].
  - g = r rotated left by s = (i+OFFSET) mod WIDTH, so g[j] = r[(j-s) mod WIDTH].
  - out[i] = (~(g[3]|g[4]|g[0]) & g[1]) | (~g[2] & k[i]) | (g[2] & g[0]).
  - Purely combinational inside a stage.
- Pipeline:
  - Stage registers v[r], d[r] for r = 0..ROUNDS-1.
  - Stage 0 loads R(in_data, key[0]). Stage r loads R(d[r-1], key[r]).
  - out_valid = v[ROUNDS-1]; out_data = d[ROUNDS-1].
- Flow control:
  - adv[ROUNDS-1] = ~v[ROUNDS-1] | out_ready.
  - adv[r] = ~v[r] | adv[r+1].
  - in_ready = adv[0].
  - On each edge where adv[r] is high, stage r takes the upstream valid/data. Otherwise it holds.
- Latency and throughput:
  - A word accepted at edge n appears on out_data after edge n+ROUNDS-1.
  - Throughput is 1 word/cycle while out_ready is high.
  - No word is lost or duplicated under any out_ready pattern.
  - out_data is stable while out_valid & ~out_ready.
- Keys:
  - key[key_idx] <= key_data on an edge with key_we.
  - A key is sampled when a stage loads. Data already resident in a stage is not re-scrambled by a key write.
  - A write in the same cycle as a load uses the old key; the new key applies from the next edge.
  - key_idx >= ROUNDS: write ignored.
- Reset:
  - All v[] = 0, d[] = 0, all keys = 0.
  - Resulting outputs: out_valid = 0, out_data = 0, in_ready = 1 from the first cycle after reset.
  - Reset mid-stream flushes in-flight words without emitting them. An in_valid present during rst is not accepted.

Optional Feature:
SCRAMBLE_BYPASS_EN:
- Defined: bypass port exists. A word accepted with bypass = 1 passes through every stage unmodified; its bypass flag travels with the word, one bit per stage. Latency and handshake are identical to scrambled words. Bypassed and scrambled words may interleave freely.
- Undefined: port absent; every word is scrambled.

Test Plan:
1. WIDTH=5, ROUNDS=1, keys 0, out_ready=1: in_data 5'b00001 -> out_data 5'b10000 one cycle after accept; 5'b11111 -> 5'b11111.
2. ROUNDS=1, key[0]=5'b11111, in_data 5'b00000 -> 5'b11111; then key[0]=0, in_data 5'b00000 -> 5'b00000.
3. ROUNDS=2, keys 0, in_data 5'b00001 -> out_data 5'b01000, out_valid exactly 2 cycles after accept.
4. ROUNDS=2, stream 8 words with out_ready toggling 1,0,0,1,... -> all 8 emitted in order, none dropped or duplicated, out_data stable while stalled, in_ready low only when both stages are full and out_ready=0.
5. Reset asserted with 2 words in flight -> next cycle out_valid=0, out_data=0, keys read back 0 via scenario 2 behaviour, in_ready=1; no stale word emitted afterwards.
6. With SCRAMBLE_BYPASS_EN, alternate bypass 1/0 on in_data 5'b00001 (ROUNDS=2, keys 0) -> outputs 5'b00001, 5'b01000 alternating, same latency.
